// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: stage state encodings and count width helper
package pipe_skid_reg_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;
  function automatic int cnt_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction
endpackage

// File: rtl/pipe_skid_reg_skid_stage.sv
// skid_stage: two-entry skid buffer with registered ready and valid
module skid_stage
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             c,
  input  logic             r,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             in_x, out_x;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_q;
  assign in_x      = in_valid & in_ready;
  assign out_x     = out_valid & out_ready;
  // next state: main reg always drives the output, skid catches the beat that arrives while main is stalled
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_x) begin
        main_d  = in_data;
        state_d = ONE;
      end
      ONE: if (in_x && out_x) main_d = in_data;
      else if (in_x) begin
        skid_d  = in_data;
        state_d = FULL;
      end else if (out_x) state_d = EMPTY;
      FULL: if (out_x) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  // state and data registers; data is never cleared except by reset
  always_ff @(posedge c or negedge r)
    if (!r) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: chain of skid stages with a single occupancy counter
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       c,
  input  logic                       r,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [cnt_w(STAGES)-1:0]   count
);
  localparam int CW = cnt_w(STAGES);
  logic             v   [STAGES+1];
  logic             rdy [STAGES+1];
  logic [WIDTH-1:0] d   [STAGES+1];
  logic [CW-1:0]    count_q, count_d;
  assign v[0]        = in_valid;
  assign d[0]        = in_data;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = v[STAGES];
  assign out_data    = d[STAGES];
  assign count       = count_q;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    skid_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .c(c), .r(r), .flush(flush),
      .in_valid(v[k]), .in_ready(rdy[k]), .in_data(d[k]),
      .out_valid(v[k+1]), .out_ready(rdy[k+1]), .out_data(d[k+1])
    );
  end
  // occupancy tracks chain-boundary transfers only; flush wins over both
  always_comb
    count_d = flush ? '0 : count_q + CW'(in_valid & in_ready) - CW'(out_valid & out_ready);
  // occupancy register
  always_ff @(posedge c or negedge r)
    if (!r) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and scoreboarded checks on 1- and 2-stage chains
module tb_pipe_skid_reg;
  logic        c = 1'b0, r = 1'b0;
  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [15:0] a_in_data = 0, a_out_data, b_in_data = 0, b_out_data;
  logic [1:0]  a_count;
  logic [2:0]  b_count;
  int          vectors = 0, miscompares = 0;
  always #5 c = ~c;
  pipe_skid_reg #(.WIDTH(16), .STAGES(1), .RESET_VAL(16'h0000)) u_a (
    .c(c), .r(r), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .count(a_count));
  pipe_skid_reg #(.WIDTH(16), .STAGES(2), .RESET_VAL(16'h0000)) u_b (
    .c(c), .r(r), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .count(b_count));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge c);
    #1;
  endtask
  initial begin
    logic [15:0] q[$];
    logic        ix, ox;
    logic [15:0] od, next;
    int          rcv, cyc;
    a_in_valid = 1; a_in_data = 16'hBEEF; b_in_valid = 1; b_in_data = 16'hBEEF;
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_count", a_count, 0);
    chk("rst_out_data", a_out_data, 16'h0000);
    tick();
    chk("rst_held_out_valid", a_out_valid, 0);
    chk("rst_held_count", b_count, 0);
    #2 r = 1;
    tick();
    chk("rst_first_accept_valid", a_out_valid, 1);
    chk("rst_first_accept_data", a_out_data, 16'hBEEF);
    chk("rst_first_accept_count", a_count, 1);
    chk("rst_b_latency_valid", b_out_valid, 0);
    a_in_valid = 0; b_in_valid = 0; a_flush = 1; b_flush = 1;
    tick();
    a_flush = 0; b_flush = 0;
    chk("clr_a_count", a_count, 0);
    chk("clr_b_count", b_count, 0);
    b_out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      b_in_valid = 1; b_in_data = 16'(i);
      chk("stream_in_ready", b_in_ready, 1);
      tick();
      if (i == 1) chk("stream_latency_valid", b_out_valid, 0);
      else begin
        chk("stream_out_valid", b_out_valid, 1);
        chk("stream_out_data", b_out_data, i - 1);
        chk("stream_count", b_count, 2);
      end
    end
    b_in_valid = 0;
    tick();
    chk("stream_last_data", b_out_data, 16'h0010);
    chk("stream_last_count", b_count, 1);
    tick();
    chk("stream_drained_valid", b_out_valid, 0);
    chk("stream_drained_count", b_count, 0);
    a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h000A;
    tick();
    chk("bp_count_a", a_count, 1);
    a_in_data = 16'h000B;
    tick();
    chk("bp_count_ab", a_count, 2);
    chk("bp_in_ready_full", a_in_ready, 0);
    chk("bp_head", a_out_data, 16'h000A);
    a_in_data = 16'h000C;
    tick();
    chk("bp_c_held_count", a_count, 2);
    chk("bp_c_held_ready", a_in_ready, 0);
    a_out_ready = 1;
    tick();
    chk("bp_out_b", a_out_data, 16'h000B);
    chk("bp_c_not_taken", a_count, 1);
    chk("bp_ready_back", a_in_ready, 1);
    tick();
    chk("bp_out_c_valid", a_out_valid, 1);
    chk("bp_out_c", a_out_data, 16'h000C);
    a_in_valid = 0;
    tick();
    chk("bp_empty_valid", a_out_valid, 0);
    chk("bp_empty_count", a_count, 0);
    a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h004A;
    tick();
    a_in_data = 16'h004B;
    tick();
    chk("full_count", a_count, 2);
    a_in_data = 16'h004C; a_out_ready = 1;
    tick();
    chk("full_edge1_data", a_out_data, 16'h004B);
    chk("full_edge1_count", a_count, 1);
    tick();
    chk("full_edge2_data", a_out_data, 16'h004C);
    chk("full_edge2_count", a_count, 1);
    a_in_valid = 0;
    tick();
    chk("full_drain_count", a_count, 0);
    b_out_ready = 0; b_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      b_in_data = 16'h0031 + 16'(i);
      tick();
    end
    chk("flush_pre_count", b_count, 3);
    b_flush = 1; b_in_data = 16'h0055; b_out_ready = 1;
    tick();
    b_flush = 0; b_in_valid = 0;
    chk("flush_out_valid", b_out_valid, 0);
    chk("flush_count", b_count, 0);
    chk("flush_in_ready", b_in_ready, 1);
    tick();
    tick();
    chk("flush_no_55_valid", b_out_valid, 0);
    b_out_ready = 0; b_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      b_in_data = 16'h0061 + 16'(i);
      tick();
    end
    b_in_valid = 0;
    chk("arst_pre_count", b_count, 3);
    #2 r = 0;
    #1;
    chk("arst_out_valid", b_out_valid, 0);
    chk("arst_count", b_count, 0);
    chk("arst_in_ready", b_in_ready, 1);
    tick();
    r = 1;
    next = 16'h1000; rcv = 0; cyc = 0;
    while (rcv < 10000 && cyc < 40000) begin
      b_in_valid  = ($urandom_range(7) != 0);
      b_in_data   = next;
      b_out_ready = ($urandom_range(7) != 0);
      ix = b_in_valid & b_in_ready;
      ox = b_out_valid & b_out_ready;
      od = b_out_data;
      chk("rnd_count", b_count, q.size());
      if (ox) begin
        chk("rnd_nonempty", q.size() > 0, 1);
        if (q.size() > 0) chk("rnd_data", od, q.pop_front());
        rcv++;
      end
      if (ix) begin
        q.push_back(next);
        next++;
      end
      tick();
      cyc++;
    end
    b_in_valid = 0; b_out_ready = 0;
    chk("rnd_beats", rcv, 10000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
